uart_tx_fifo: RTL and testbench

Buffered UART transmitter that serialises bytes onto the `tx` line: 8 data bits, LSB first, one start bit, one stop bit, no flow control. It is the sending end of the same serial link the image-loading path receives on. It returns processed image bytes (e.g. Sobel output) to the host through the top-level `tx` pin. A small internal FIFO absorbs bursts from the pixel pipeline, so producers never have to wait for a byte period.

---
 rtl/uart_tx_fifo.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: 8 data bits LSB first, 1 start, 1 stop, no flow control.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between data and stop (11-bit frame).
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       fifo_full,
  output logic       overflow,
  output logic       tx_busy,
  output logic       tx
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int CW           = $clog2(BAUD_CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  logic [7:0]    r_mem [0:FIFO_DEPTH-1];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_overflow;
  logic          r_busy;
  logic          r_tx;
  state_t        r_state;
  logic [CW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;

  logic          w_empty;
  logic          w_wr;
  logic          w_pop;
  logic          w_baud_end;
  logic          w_tx_nxt;
  logic [AW:0]   w_count_nxt;
  state_t        w_state_nxt;

  assign w_empty    = (r_count == (AW+1)'(0));
  assign w_wr       = pi_flag & ~r_full;
  assign w_baud_end = (r_baud_cnt == CW'(BAUD_CNT_MAX - 1));

  assign fifo_full  = r_full;
  assign overflow   = r_overflow;
  assign tx_busy    = r_busy;
  assign tx         = r_tx;

  always_comb begin
    case ({w_wr, w_pop})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= pi_data;
    end
  end

  // A write attempted while full is dropped even if a pop frees a slot this cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr   <= AW'(0);
      r_rd_ptr   <= AW'(0);
      r_count    <= (AW+1)'(0);
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (pi_flag && r_full) begin
        r_overflow <= 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW+1)'(FIFO_DEPTH));
      r_busy  <= (r_state != S_IDLE) | ~w_empty;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        w_tx_nxt = 1'b0;
        if (w_baud_end) begin
          w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        w_tx_nxt = r_shift[r_bit_cnt];
        if (w_baud_end && (r_bit_cnt == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end else begin
          w_state_nxt = S_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        w_tx_nxt = ^r_shift;
        if (w_baud_end) begin
          w_state_nxt = S_STOP;
        end else begin
          w_state_nxt = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_baud_end && !w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end else if (w_baud_end) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The line follows the current state one cycle later, hence the 2-cycle start latency.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_tx       <= 1'b1;
      r_baud_cnt <= CW'(0);
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      if ((r_state == S_IDLE) || (w_state_nxt != r_state) || w_baud_end) begin
        r_baud_cnt <= CW'(0);
      end else begin
        r_baud_cnt <= r_baud_cnt + CW'(1);
      end
      if (r_state != S_DATA) begin
        r_bit_cnt <= 3'd0;
      end else if (w_baud_end) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end else begin
        r_bit_cnt <= r_bit_cnt;
      end
      if (w_pop) begin
        r_shift <= r_mem[r_rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo at 52 clocks/bit: directed writes push expected bytes,
// a serial monitor decodes frames mid-bit and checks framing, gaps and idle behaviour.
module tb_uart_tx_fifo;

  localparam int BIT = 52;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [7:0] pi_data;
  logic       pi_flag;
  logic       fifo_full;
  logic       overflow;
  logic       tx_busy;
  logic       tx;

  int         checks = 0;
  int         errors = 0;
  int         rx_cnt = 0;
  logic [8:0] exp_q[$];

  uart_tx_fifo #(
    .CLK_FREQ  (500_000),
    .UART_BPS  (9600),
    .FIFO_DEPTH(16)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .pi_data  (pi_data),
    .pi_flag  (pi_flag),
    .fifo_full(fifo_full),
    .overflow (overflow),
    .tx_busy  (tx_busy),
    .tx       (tx)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_neg(input int n, output logic ab);
    ab = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        ab = 1'b1;
        return;
      end
    end
  endtask

  // Drive one write strobe; the byte is sampled at the following rising edge.
  task automatic send(input logic [7:0] d, input logic acc);
    @(negedge sys_clk);
    pi_data = d;
    pi_flag = 1'b1;
    if (acc) exp_q.push_back({^d, d});
  endtask

  task automatic send_done();
    @(negedge sys_clk);
    pi_flag = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || tx_busy !== 1'b0) && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, budget);
    end
    repeat (5) @(negedge sys_clk);
  endtask

  initial begin : monitor
    logic [7:0] rx;
    logic [8:0] e;
    logic       rx_par;
    logic       ab;
    logic       hs;
    hs = 1'b0;
    rx_par = 1'b0;
    forever begin
      if (!hs) begin
        @(negedge sys_clk);
        hs = sys_rst_n && (tx === 1'b0);
      end
      if (hs) begin
        hs = 1'b0;
        rx = 8'h00;
        ab = 1'b0;
        for (int b = 0; b < NB; b++) begin
          wait_neg((b == 0) ? BIT / 2 : BIT, ab);
          if (ab) break;
          if (b == 0) chk("start_bit", 32'(tx), 32'd0);
          else if (b <= 8) rx[b-1] = tx;
          else if (b == NB - 1) chk("stop_bit", 32'(tx), 32'd1);
          else rx_par = tx;
        end
        if (!ab) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got 0x%0h required no frame", rx);
          end else begin
            e = exp_q.pop_front();
            chk("rx_byte", 32'(rx), 32'(e[7:0]));
`ifdef UART_TX_PARITY_EN
            chk("parity_bit", 32'(rx_par), 32'(e[8]));
`endif
            rx_cnt++;
          end
          wait_neg(BIT / 2 - 1, ab);
          if (!ab) begin
            chk("stop_end", 32'(tx), 32'd1);
            wait_neg(1, ab);
            if (!ab) begin
              if (exp_q.size() != 0) begin
                chk("back_to_back", 32'(tx), 32'd0);
                hs = (tx === 1'b0);
              end else begin
                chk("idle_tx", 32'(tx), 32'd1);
                chk("idle_busy", 32'(tx_busy), 32'd0);
              end
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #900_000_000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int   base;
    logic full_seen;
    sys_rst_n = 1'b0;
    pi_flag   = 1'b0;
    pi_data   = 8'h00;
    repeat (3) @(negedge sys_clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_full", 32'(fifo_full), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_busy", 32'(tx_busy), 32'd0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("idle_after_reset", 32'(tx), 32'd1);

    // Single byte: write at edge N, line falls at edge N+2.
    base = rx_cnt;
    send(8'hA5, 1'b1);
    send_done();
    chk("lat_n0_tx", 32'(tx), 32'd1);
    @(negedge sys_clk);
    chk("lat_n1_tx", 32'(tx), 32'd1);
    chk("lat_n1_busy", 32'(tx_busy), 32'd1);
    @(negedge sys_clk);
    chk("lat_n2_tx", 32'(tx), 32'd0);
    wait_idle("single", 1000);
    chk("single_count", 32'(rx_cnt - base), 32'd1);

    // Burst of 16: the first byte is popped immediately, so the FIFO never fills.
    base = rx_cnt;
    full_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1'b1);
      full_seen |= fifo_full;
    end
    send_done();
    full_seen |= fifo_full;
    chk("burst_full", 32'(full_seen), 32'd0);
    wait_idle("burst", 9000);
    chk("burst_count", 32'(rx_cnt - base), 32'd16);

    // Overflow: 17 accepted (16 stored + 1 in flight), the 18th dropped.
    base = rx_cnt;
    for (int i = 0; i < 18; i++) begin
      send(8'h40 + 8'(i), (i < 17) ? 1'b1 : 1'b0);
      if (i == 17) begin
        chk("full_after_17", 32'(fifo_full), 32'd1);
        chk("no_overflow_yet", 32'(overflow), 32'd0);
      end
    end
    send_done();
    chk("ovf_full", 32'(fifo_full), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    wait_idle("overflow", 10000);
    chk("ovf_count", 32'(rx_cnt - base), 32'd17);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_full_cleared", 32'(fifo_full), 32'd0);

    // Reset during data bit 3 of 0x11 (a 0 on the line), with two bytes still queued.
    base = rx_cnt;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    send_done();
    repeat (234) @(negedge sys_clk);
    chk("pre_reset_tx", 32'(tx), 32'd0);
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", 32'(tx), 32'd1);
    chk("rst_mid_busy", 32'(tx_busy), 32'd0);
    chk("rst_mid_full", 32'(fifo_full), 32'd0);
    chk("rst_mid_overflow", 32'(overflow), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (60) @(negedge sys_clk);
    chk("post_reset_tx", 32'(tx), 32'd1);
    chk("post_reset_busy", 32'(tx_busy), 32'd0);
    chk("post_reset_count", 32'(rx_cnt - base), 32'd0);
    send(8'h3C, 1'b1);
    send_done();
    wait_idle("after_reset", 1000);
    chk("after_reset_count", 32'(rx_cnt - base), 32'd1);

`ifdef UART_TX_PARITY_EN
    base = rx_cnt;
    send(8'h07, 1'b1);
    send_done();
    wait_idle("parity_07", 1000);
    send(8'h03, 1'b1);
    send_done();
    wait_idle("parity_03", 1000);
    chk("parity_count", 32'(rx_cnt - base), 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
